// File: rtl/monster_patrol_if.sv
// monster_patrol_if: sprite ROM bus between the monster renderer (master)
// and its synchronous pixel ROM (slave). rom_data is valid one clock after
// rom_addr is presented.
interface monster_patrol_if #(
  parameter int ADDRW     = 14,
  parameter int COLR_BITS = 4
);
  logic [ADDRW-1:0]     rom_addr;
  logic [COLR_BITS-1:0] rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/monster_patrol.sv
// monster_patrol: a walking sprite that patrols between patrol_l and
// patrol_r. It pauses at each end before turning round, and it steps
// through its animation frames while walking. It also streams one sprite
// row per scanline from a synchronous ROM.
// Optional feature: define MONSTER_MIRROR_EN to flip the sprite
// horizontally while it walks left.
module monster_patrol #(
  parameter int CORDW     = 16,
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 96,
  parameter int FRAMES    = 2,
  parameter int COLR_BITS = 4,
  parameter int SPEED     = 1,
  parameter int ANIM_DIV  = 8,
  parameter int TURN_WAIT = 16,
  parameter int GROUND_Y  = 469
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    replay,
  input  logic                    frame,
  input  logic                    line,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic signed [19:0]      x_init,
  input  logic signed [19:0]      y_init,
  input  logic signed [19:0]      screen_height,
  input  logic signed [CORDW-1:0] patrol_l,
  input  logic signed [CORDW-1:0] patrol_r,
  monster_patrol_if.master        rom,
  output logic [COLR_BITS-1:0]    pix,
  output logic                    drawing,
  output logic signed [CORDW-1:0] mon_x,
  output logic signed [CORDW-1:0] mon_y,
  output logic                    dir
);

  localparam int ADDRW = $clog2(WIDTH * HEIGHT * FRAMES);
  localparam int ROWW  = (HEIGHT > 1)    ? $clog2(HEIGHT)    : 1;
  localparam int COLW  = (WIDTH > 1)     ? $clog2(WIDTH)     : 1;
  localparam int FW    = (FRAMES > 1)    ? $clog2(FRAMES)    : 1;
  localparam int ACW   = (ANIM_DIV > 1)  ? $clog2(ANIM_DIV)  : 1;
  localparam int TCW   = (TURN_WAIT > 1) ? $clog2(TURN_WAIT) : 1;

  // Patrol states
  localparam logic [1:0] WALK_R = 2'd0;
  localparam logic [1:0] WALK_L = 2'd1;
  localparam logic [1:0] TURN_R = 2'd2;
  localparam logic [1:0] TURN_L = 2'd3;

  // Draw states
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_POS = 2'd1;
  localparam logic [1:0] DRAW     = 2'd2;

  logic                    restart;
  logic [1:0]              pstate;
  logic [FW-1:0]           anim;
  logic [ACW-1:0]          anim_cnt;
  logic [TCW-1:0]          turn_cnt;
  logic signed [CORDW-1:0] step_r, step_l, x_prev, mon_y_end, row_diff;
  logic                    in_range, walking;

  logic [1:0]              dstate;
  logic [ROWW-1:0]         row;
  logic [COLW-1:0]         col, col_sel, col_addr;
  logic                    issue, pix_valid;
  logic [ADDRW-1:0]        addr;

  assign restart   = !i_rst_n || replay;
  assign step_r    = mon_x + CORDW'(SPEED);
  assign step_l    = mon_x - CORDW'(SPEED);
  assign x_prev    = mon_x - CORDW'(1);
  assign mon_y_end = mon_y + CORDW'(HEIGHT);
  assign row_diff  = sy - mon_y;
  assign in_range  = (sy >= mon_y) && (sy < mon_y_end);
  assign walking   = (pstate == WALK_R) || (pstate == WALK_L);

  // Bits of x_init beyond CORDW and the upper part of row_diff are unused.
  logic unused_bits;
  assign unused_bits = &{1'b0, x_init, row_diff};

  // Patrol movement: walk, clamp at the bound, pause, then reverse.
  always_ff @(posedge clk) begin
    if (restart) begin
      mon_x    <= CORDW'(x_init);
      pstate   <= WALK_R;
      dir      <= 1'b0;
      turn_cnt <= '0;
    end else if (frame) begin
      case (pstate)
        WALK_R: begin
          if (step_r >= patrol_r) begin
            mon_x  <= patrol_r;
            pstate <= TURN_R;
          end else begin
            mon_x <= step_r;
          end
        end
        WALK_L: begin
          if (step_l <= patrol_l) begin
            mon_x  <= patrol_l;
            pstate <= TURN_L;
          end else begin
            mon_x <= step_l;
          end
        end
        TURN_R: begin
          if (turn_cnt == TCW'(TURN_WAIT - 1)) begin
            turn_cnt <= '0;
            pstate   <= WALK_L;
            dir      <= 1'b1;
          end else begin
            turn_cnt <= turn_cnt + TCW'(1);
          end
        end
        default: begin
          if (turn_cnt == TCW'(TURN_WAIT - 1)) begin
            turn_cnt <= '0;
            pstate   <= WALK_R;
            dir      <= 1'b0;
          end else begin
            turn_cnt <= turn_cnt + TCW'(1);
          end
        end
      endcase
    end
  end

  // Animation advances every ANIM_DIV walking frames and freezes while turning.
  always_ff @(posedge clk) begin
    if (restart) begin
      anim     <= '0;
      anim_cnt <= '0;
    end else if (frame && walking) begin
      if (anim_cnt == ACW'(ANIM_DIV - 1)) begin
        anim_cnt <= '0;
        anim     <= (anim == FW'(FRAMES - 1)) ? '0 : anim + FW'(1);
      end else begin
        anim_cnt <= anim_cnt + ACW'(1);
      end
    end
  end

  // Sprite top row follows the vertical scroll every clock.
  always_ff @(posedge clk) begin
    mon_y <= CORDW'(GROUND_Y - HEIGHT) - CORDW'(y_init - screen_height);
  end

  // ROM request for this cycle: column 0 one pixel ahead of mon_x, then one
  // column per clock. A line pulse suppresses the request so the row aborts.
  always_comb begin
    issue   = 1'b0;
    col_sel = '0;
    case (dstate)
      WAIT_POS: issue = !line && (sx == x_prev);
      DRAW: begin
        issue   = !line;
        col_sel = col;
      end
      default: ;
    endcase
  end

  // Column address, optionally mirrored while walking left.
  always_comb begin
`ifdef MONSTER_MIRROR_EN
    col_addr = dir ? (COLW'(WIDTH - 1) - col_sel) : col_sel;
`else
    col_addr = col_sel;
`endif
  end

  assign addr = ADDRW'(anim) * ADDRW'(WIDTH * HEIGHT)
              + ADDRW'(row) * ADDRW'(WIDTH)
              + ADDRW'(col_addr);
  assign rom.rom_addr = issue ? addr : '0;

  // Draw FSM: any line pulse re-evaluates the row, so it also aborts a draw.
  always_ff @(posedge clk) begin
    if (restart) begin
      dstate    <= IDLE;
      row       <= '0;
      col       <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= issue;
      if (line) begin
        dstate <= in_range ? WAIT_POS : IDLE;
        col    <= '0;
        if (in_range) row <= row_diff[ROWW-1:0];
      end else begin
        case (dstate)
          WAIT_POS: begin
            if (sx == x_prev) begin
              dstate <= DRAW;
              col    <= COLW'(1);
            end
          end
          DRAW: begin
            if (col == COLW'(WIDTH - 1)) begin
              dstate <= IDLE;
              col    <= '0;
            end else begin
              col <= col + COLW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ROM data is shown only for the cycle after a request; index 0 is transparent.
  assign pix     = pix_valid ? rom.rom_data : '0;
  assign drawing = pix_valid && (rom.rom_data != '0);

endmodule

// File: tb/tb_monster_patrol.sv
// tb_monster_patrol: directed and randomized checks of patrol motion,
// animation, scroll tracking and row streaming against a beam-position
// reference model. Honours MONSTER_MIRROR_EN when defined.
module tb_monster_patrol;
  localparam int CORDW = 16, WIDTH = 64, HEIGHT = 96, FRAMES = 2;
  localparam int SPEED = 1, ANIM_DIV = 8, TURN_WAIT = 16, GROUND_Y = 469;
  localparam int DEPTH = WIDTH * HEIGHT * FRAMES;
`ifdef MONSTER_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    i_rst_n, replay, frame, line;
  logic signed [CORDW-1:0] sx, sy, patrol_l, patrol_r;
  logic signed [19:0]      x_init, y_init, screen_height;
  logic [3:0]              pix;
  logic                    drawing, dir;
  logic signed [CORDW-1:0] mon_x, mon_y;

  monster_patrol_if #(.ADDRW(14), .COLR_BITS(4)) rom_bus ();

  monster_patrol #(
    .CORDW(CORDW), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FRAMES(FRAMES),
    .COLR_BITS(4), .SPEED(SPEED), .ANIM_DIV(ANIM_DIV),
    .TURN_WAIT(TURN_WAIT), .GROUND_Y(GROUND_Y)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .replay(replay), .frame(frame), .line(line),
    .sx(sx), .sy(sy), .x_init(x_init), .y_init(y_init),
    .screen_height(screen_height), .patrol_l(patrol_l), .patrol_r(patrol_r),
    .rom(rom_bus), .pix(pix), .drawing(drawing), .mon_x(mon_x),
    .mon_y(mon_y), .dir(dir)
  );

  // Synchronous sprite ROM
  logic [3:0] mem [0:DEPTH-1];
  always @(posedge clk) rom_bus.rom_data <= mem[rom_bus.rom_addr];

  int checks = 0;
  int failures = 0;

  // Reference model state
  int xi, yi, sh, pl, pr;
  int m_x, m_dir, m_turning, m_turn_cnt, m_walk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_mon_y();
    return GROUND_Y - HEIGHT - (yi - sh);
  endfunction

  function automatic int m_anim();
    return (m_walk / ANIM_DIV) % FRAMES;
  endfunction

  function automatic int addr_of(input int r, input int k);
    int c;
    c = (MIRROR && m_dir == 1) ? (WIDTH - 1 - k) : k;
    return m_anim() * WIDTH * HEIGHT + r * WIDTH + c;
  endfunction

  task automatic model_reset();
    m_x = xi; m_dir = 0; m_turning = 0; m_turn_cnt = 0; m_walk = 0;
  endtask

  task automatic model_frame();
    if (m_turning == 0) begin
      m_walk++;
      if (m_dir == 0) begin
        m_x += SPEED;
        if (m_x >= pr) begin m_x = pr; m_turning = 1; m_turn_cnt = 0; end
      end else begin
        m_x -= SPEED;
        if (m_x <= pl) begin m_x = pl; m_turning = 1; m_turn_cnt = 0; end
      end
    end else begin
      m_turn_cnt++;
      if (m_turn_cnt == TURN_WAIT) begin m_turning = 0; m_dir = 1 - m_dir; end
    end
  endtask

  task automatic set_bounds();
    x_init = 20'(xi); y_init = 20'(yi); screen_height = 20'(sh);
    patrol_l = 16'(pl); patrol_r = 16'(pr);
  endtask

  task automatic do_restart(input bit use_replay);
    next();
    if (use_replay) replay = 1'b1; else i_rst_n = 1'b0;
    next();
    replay = 1'b0; i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic frame_pulse(input bit chk);
    next(); frame = 1'b1;
    next(); frame = 1'b0;
    model_frame();
    if (chk) begin
      #2;
      check("mon_x", mon_x, m_x);
      check("dir", dir, m_dir);
    end
  endtask

  // One scanline: line pulse at sx0, then ncyc beam cycles checked against
  // the expected fetch/pixel position derived from mon_x and the row.
  task automatic run_line(input int sy_v, input int sx0, input int ncyc);
    int r, k, ea, ep;
    bit act;
    next(); line = 1'b1; sy = 16'(sy_v); sx = 16'(sx0);
    r = sy_v - exp_mon_y();
    act = (r >= 0) && (r < HEIGHT);
    for (int i = 1; i <= ncyc; i++) begin
      next(); line = 1'b0; sx = 16'(sx0 + i);
      #2;
      k = sx0 + i - m_x;
      ea = (act && k + 1 >= 0 && k + 1 < WIDTH) ? addr_of(r, k + 1) : 0;
      ep = (act && k >= 0 && k < WIDTH) ? int'(mem[addr_of(r, k)]) : 0;
      check("rom_addr", rom_bus.rom_addr, ea);
      check("pix", pix, ep);
      check("drawing", drawing, (ep != 0) ? 1 : 0);
    end
  endtask

  task automatic rand_line();
    run_line(exp_mon_y() + $urandom_range(0, HEIGHT + 5) - 3, m_x - 20, 90);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    i_rst_n = 1'b0; replay = 1'b0; frame = 1'b0; line = 1'b0;
    sx = '0; sy = '0;
    xi = 100; yi = 96; sh = 0; pl = 60; pr = 103;
    set_bounds();
    do_restart(1'b0);

    // Reset state
    #2;
    check("rst_mon_x", mon_x, 100);
    check("rst_dir", dir, 0);
    check("rst_drawing", drawing, 0);
    check("rst_pix", pix, 0);
    check("rst_rom_addr", rom_bus.rom_addr, 0);
    check("rst_mon_y", mon_y, 277);

    // Row 3 at mon_y=277, boundary rows and the row just below the sprite
    run_line(280, m_x - 20, 90);
    run_line(277 + HEIGHT, m_x - 20, 90);
    run_line(276, m_x - 20, 90);
    run_line(277, m_x - 20, 90);
    run_line(277 + HEIGHT - 1, m_x - 20, 90);

    // Walk to the right bound, pause, then turn left
    for (int i = 0; i < 3; i++) frame_pulse(1'b1);
    check("turn_r_x", mon_x, 103);
    for (int i = 0; i < 15; i++) frame_pulse(1'b1);
    check("turn_hold_dir", dir, 0);
    rand_line();
    frame_pulse(1'b1);
    check("walk_l_dir", dir, 1);
    frame_pulse(1'b1);
    check("walk_l_x", mon_x, 102);

    // Long randomized patrol with interleaved scanlines
    for (int i = 0; i < 70; i++) begin
      frame_pulse(1'b1);
      if ($urandom_range(0, 5) == 0) rand_line();
    end

    // Scroll tracking
    for (int i = 0; i < 4; i++) begin
      yi = $urandom_range(0, 200); sh = $urandom_range(0, 200);
      set_bounds();
      next(); next(); #2;
      check("mon_y", mon_y, exp_mon_y());
      rand_line();
    end
    yi = 96; sh = 0; set_bounds();
    next(); next();

    // Replay in the middle of a row
    for (int i = 0; i < 12; i++) frame_pulse(1'b0);
    run_line(exp_mon_y() + 10, m_x - 20, 30);
    next(); replay = 1'b1;
    next(); replay = 1'b0;
    model_reset();
    #2;
    check("replay_drawing", drawing, 0);
    check("replay_pix", pix, 0);
    check("replay_mon_x", mon_x, 100);
    check("replay_dir", dir, 0);
    run_line(exp_mon_y() + 40, m_x - 20, 90);

    // Animation: steps at the 8th walk pulse, holds through the turn
    pr = 110; set_bounds();
    for (int i = 1; i <= 32; i++) begin
      frame_pulse(1'b1);
      if (i == 7 || i == 8 || i == 20 || i == 31 || i == 32) rand_line();
    end

    // Row aborted by a line pulse, then re-evaluated in and out of range
    run_line(exp_mon_y() + 5, m_x - 20, 40);
    run_line(exp_mon_y() + 60, m_x - 10, 90);
    run_line(exp_mon_y() + 7, m_x - 20, 40);
    run_line(exp_mon_y() + HEIGHT + 2, m_x - 10, 80);

    // Reset in the middle of a row
    run_line(exp_mon_y() + 20, m_x - 20, 35);
    do_restart(1'b0);
    #2;
    check("rst_mid_drawing", drawing, 0);
    check("rst_mid_mon_x", mon_x, 100);
    check("rst_mid_addr", rom_bus.rom_addr, 0);
    rand_line();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
